score_keeper: RTL and testbench
===============================

# score_keeper

Frame-rate scoring and seven-segment display stage for the dino game. Sits downstream of the top-level game FSM and the VGA controller. It consumes the 2-bit game `state` and the `vsync` frame strobe, counts a 4-digit BCD score while the game is running, and latches a high score on game over. It drives the board's 4-digit multiplexed seven-segment display.

## Interface

Parameters:
- `FRAMES_PER_POINT`, default 6: frame ticks per score increment (60 Hz → 10 points/s); legal range 1..255.
- `REFRESH_BITS`, default 17: width of the free-running display refresh counter; top 2 bits select the digit.

Ports:
- `clk` input 1: system clock (100 MHz board clock).
- `rst` input 1: asynchronous, active-high reset; clears all state immediately.
- `vsync` input 1: VGA vsync, active-low pulse, generated synchronously from `clk`-derived pixel clock.
- `state` input 2: game FSM state; 00 idle, 01 running, 10 unused, 11 game over.
- `score_bcd` output 16: current score, 4 BCD digits, [3:0] = ones.
- `high_bcd` output 16: high score, same format.
- `seg` output 7: segment drive, active-low, `seg[0]`=a … `seg[6]`=g.
- `an` output 4: digit anodes, active-low, `an[0]` = ones digit.

## Operation

- **Frame tick.** `vs_q` registers `vsync`. `tick = vs_q & ~vsync`, i.e. the falling edge of vsync, exactly one `clk` cycle per frame.
- **Edge detect on state.** `state_q` registers `state`.
  - `new_game = (state_q==00) && (state==01)`.
  - `over = (state_q!=11) && (state==11)`.
- **Frame counter** (8 bits):
  - Cleared whenever `state != 01`.
  - In state 01, increments on `tick`.
  - When a tick arrives with the counter at `FRAMES_PER_POINT-1`, the counter wraps to 0 and the score increments.
- **Score increment.** 4-digit BCD with ripple carry: a digit at 9 goes to 0 and carries into the next digit. At 9999 the score saturates and holds 9999; it never wraps.
- **New game.** `new_game` clears the score and frame counter. It has priority over a coincident tick.
- **Game over.** On `over`, `high_bcd` ← `score_bcd` if `score_bcd > high_bcd`. The comparison is unsigned on the 16-bit value, which is valid for legal BCD. No score increment happens in state 11, so the compare uses the final score.
- **Other states.** State 10 behaves as 00: no counting, score held.
- **Display source.** Shows `high_bcd` when `state==00`, otherwise `score_bcd`.
- **Refresh counter.** Free-running, `REFRESH_BITS` wide. Digit select `sel = cnt[REFRESH_BITS-1 -: 2]`:
  - sel 0 → `an`=1110, digit [3:0].
  - sel 1 → `an`=1101, digit [7:4].
  - sel 2 → `an`=1011, digit [11:8].
  - sel 3 → `an`=0111, digit [15:12].
  - Leading zeros are displayed.
- **Segment patterns** (`seg[6:0]`, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any non-BCD nibble → 1111111 (blank).
- **Registered outputs.** `seg` and `an` are registered.

## Timing

- **Reset values:** `vs_q`=1, `state_q`=00, frame counter 0, `score_bcd`=0000, `high_bcd`=0000, refresh counter 0, `an`=1110, `seg`=1000000.
- **Reset mid-game:** everything clears asynchronously; the high score is lost. Only `rst` clears the high score; a new game does not.
- **Score latency:** `score_bcd` updates on the `clk` edge after the cycle in which `tick` is high with the counter at `FRAMES_PER_POINT-1`. `vsync` falls at edge N; the score changes at edge N+1.
- **High-score latency:** `high_bcd` updates on the first `clk` edge after `state` becomes 11.
- **New-game latency:** the score clears on the first edge after `state` becomes 01 from 00.
- **Game over then restart:** 11→00→01 clears the score on the 00→01 transition. Going 11→01 directly does not clear the score.
- **Display latency:** `seg`/`an` lag the digit select by 1 cycle, and lag source changes by at most 1 cycle.
- **Short vsync pulses:** a vsync low pulse shorter than one `clk` cycle is not a supported input.

## Test plan

1. **Reset.** Assert `rst` mid-count with score 0042 → all outputs take their reset values in the same cycle, with no clock needed; `an`=1110, `seg`=1000000.
2. **Counting.** `FRAMES_PER_POINT`=2, state 00→01, 10 vsync falling edges → `score_bcd`=0005; each increment lands exactly 1 cycle after the even-numbered tick.
3. **BCD carry and saturation.**
   - Preload to 0099 via ticks, then one more point → 0100.
   - Run to 9999, then 4 more points → stays 9999.
4. **High score update.**
   - Score 0123, state→11 → `high_bcd`=0123.
   - Restart 00→01, confirm score 0000 while high holds 0123; reach 0050, →11 → high stays 0123.
   - Reach 0200, →11 → high becomes 0200.
5. **Priority and gating.**
   - `new_game` coincident with `tick` → score 0000, frame counter 0.
   - Ticks in states 00, 10 and 11 → no score change.
6. **Display mux.** `REFRESH_BITS`=4, score 1234 in state 01 → `an` cycles 1110/1101/1011/0111, each held 4 cycles, with `seg` 0011001/0110000/0100100/1111001 respectively. State 00 → shows `high_bcd` digits instead.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: frame-rate BCD score counter with high-score latch and a
// 4-digit multiplexed seven-segment display driver for the dino game.
// The score advances one point every FRAMES_PER_POINT vsync frames while the
// game is running, saturates at 9999, and is compared against the high score
// when the game ends.
module score_keeper #(
    parameter int FRAMES_PER_POINT = 6,
    parameter int REFRESH_BITS     = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic [1:0]  state,
    output logic [15:0] score_bcd,
    output logic [15:0] high_bcd,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b11;

    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_POINT - 1);
    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    // Saturating 4-digit BCD increment with ripple carry between digits.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) begin
            r = v;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                        carry       = 1'b1;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    r[4*i +: 4] = r[4*i +: 4];
                end
            end
        end
        return r;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD nibbles blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    logic                    vs_q;
    logic [1:0]              state_q;
    logic [7:0]              frame_q,   frame_d;
    logic [15:0]             score_q,   score_d;
    logic [15:0]             high_q,    high_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [6:0]              seg_q,     seg_d;
    logic [3:0]              an_q,      an_d;

    logic        tick_s;
    logic        new_game_s;
    logic        over_s;
    logic [15:0] src_s;
    logic [1:0]  sel_s;
    logic [3:0]  digit_s;

    // Frame/score/high-score next-state: new game beats a coincident tick.
    always_comb begin
        tick_s     = vs_q & ~vsync;
        new_game_s = (state_q == ST_IDLE) && (state == ST_RUN);
        over_s     = (state_q != ST_OVER) && (state == ST_OVER);
        frame_d    = frame_q;
        score_d    = score_q;
        high_d     = high_q;
        if (new_game_s) begin
            frame_d = 8'd0;
            score_d = 16'h0000;
        end else if (state != ST_RUN) begin
            frame_d = 8'd0;
        end else if (tick_s) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = 8'd0;
                score_d = bcd_inc(score_q);
            end else begin
                frame_d = frame_q + 8'd1;
            end
        end else begin
            frame_d = frame_q;
        end
        if (over_s && (score_q > high_q)) begin
            high_d = score_q;
        end else begin
            high_d = high_q;
        end
    end

    // Display next-state: pick source, select digit from refresh counter top bits.
    always_comb begin
        refresh_d = refresh_q + REFRESH_ONE;
        src_s     = (state == ST_IDLE) ? high_q : score_q;
        sel_s     = refresh_q[REFRESH_BITS-1 -: 2];
        case (sel_s)
            2'd0: begin an_d = 4'b1110; digit_s = src_s[3:0];   end
            2'd1: begin an_d = 4'b1101; digit_s = src_s[7:4];   end
            2'd2: begin an_d = 4'b1011; digit_s = src_s[11:8];  end
            2'd3: begin an_d = 4'b0111; digit_s = src_s[15:12]; end
            default: begin an_d = 4'b1111; digit_s = 4'hF; end
        endcase
        seg_d = seg_decode(digit_s);
    end

    // Game-side state: edge-detect registers, frame counter, score, high score.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q    <= 1'b1;
            state_q <= ST_IDLE;
            frame_q <= 8'd0;
            score_q <= 16'h0000;
            high_q  <= 16'h0000;
        end else begin
            vs_q    <= vsync;
            state_q <= state;
            frame_q <= frame_d;
            score_q <= score_d;
            high_q  <= high_d;
        end
    end

    // Display-side state: free-running refresh counter and registered drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            an_q      <= 4'b1110;
            seg_q     <= 7'b1000000;
        end else begin
            refresh_q <= refresh_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: per-cycle scoreboard of score/high
// against a decimal reference model, plus directed display and reset checks.
module tb_score_keeper;

    localparam int FPP = 2;
    localparam int RB  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic [1:0]  state;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;
    logic [6:0]  seg;
    logic [3:0]  an;

    score_keeper #(.FRAMES_PER_POINT(FPP), .REFRESH_BITS(RB)) dut (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .state     (state),
        .score_bcd (score_bcd),
        .high_bcd  (high_bcd),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release, used to predict the digit select.
    int ncyc;
    always @(posedge clk or posedge rst) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] h;
    } exp_t;
    exp_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state (decimal score values).
    int         m_score;
    int         m_high;
    int         m_frame;
    logic [1:0] m_sq;
    logic       m_vs;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'b1000000;
            4'd1: p = 7'b1111001;
            4'd2: p = 7'b0100100;
            4'd3: p = 7'b0110000;
            4'd4: p = 7'b0011001;
            4'd5: p = 7'b0010010;
            4'd6: p = 7'b0000010;
            4'd7: p = 7'b1111000;
            4'd8: p = 7'b0000000;
            4'd9: p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, predict its effect, then compare after the edge.
    task automatic drive(input logic [1:0] s, input logic v);
        exp_t e;
        logic tk, ng, ov;
        state = s;
        vsync = v;
        tk = m_vs & ~v;
        ng = (m_sq == 2'b00) && (s == 2'b01);
        ov = (m_sq != 2'b11) && (s == 2'b11);
        if (ng) begin
            m_score = 0;
            m_frame = 0;
        end else if (s != 2'b01) begin
            m_frame = 0;
        end else if (tk) begin
            m_frame = m_frame + 1;
            if (m_frame == FPP) begin
                m_frame = 0;
                if (m_score < 9999) m_score = m_score + 1;
            end
        end
        if (ov && m_score > m_high) m_high = m_score;
        e.s = to_bcd(m_score);
        e.h = to_bcd(m_high);
        exp_q.push_back(e);
        m_sq = s;
        m_vs = v;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("score", score_bcd, e.s);
        check("high", high_bcd, e.h);
    endtask

    task automatic tick(input int n, input logic [1:0] s);
        repeat (n) begin
            drive(s, 1'b0);
            drive(s, 1'b1);
        end
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (m_score != target && guard < 30000) begin
            drive(2'b01, 1'b0);
            drive(2'b01, 1'b1);
            guard++;
        end
        check("run_to", score_bcd, to_bcd(target));
    endtask

    task automatic check_display(input logic [15:0] val, input logic [1:0] s);
        int sel;
        logic [3:0] nib;
        logic [3:0] exp_an;
        repeat (16) begin
            drive(s, 1'b1);
            sel    = (ncyc == 0) ? 0 : (((ncyc - 1) % 16) / 4);
            nib    = val[sel*4 +: 4];
            exp_an = ~(4'b0001 << sel);
            check("an", {12'h000, an}, {12'h000, exp_an});
            check("seg", {9'h000, seg}, {9'h000, seg_of(nib)});
        end
    endtask

    task automatic reset_mid_cycle();
        #2;
        rst = 1'b1;
        #1;
        check("rst_score", score_bcd, 16'h0000);
        check("rst_high", high_bcd, 16'h0000);
        check("rst_an", {12'h000, an}, 16'h000E);
        check("rst_seg", {9'h000, seg}, 16'h0040);
        state   = 2'b00;
        vsync   = 1'b1;
        m_score = 0;
        m_high  = 0;
        m_frame = 0;
        m_sq    = 2'b00;
        m_vs    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        vsync   = 1'b1;
        state   = 2'b00;
        m_score = 0;
        m_high  = 0;
        m_frame = 0;
        m_sq    = 2'b00;
        m_vs    = 1'b1;
        #3;
        check("init_score", score_bcd, 16'h0000);
        check("init_high", high_bcd, 16'h0000);
        check("init_an", {12'h000, an}, 16'h000E);
        check("init_seg", {9'h000, seg}, 16'h0040);
        @(negedge clk);
        rst = 1'b0;

        // Counting: 10 frame ticks at 2 frames/point gives 5 points.
        drive(2'b00, 1'b1);
        drive(2'b01, 1'b1);
        tick(10, 2'b01);
        check("count10", score_bcd, 16'h0005);

        // Game over latches high; ticks in 11, 00 and 10 leave the score alone.
        drive(2'b11, 1'b1);
        check("high5", high_bcd, 16'h0005);
        tick(2, 2'b11);
        drive(2'b00, 1'b1);
        tick(2, 2'b00);
        drive(2'b10, 1'b1);
        tick(2, 2'b10);
        drive(2'b00, 1'b1);
        check("gated", score_bcd, 16'h0005);

        // New game clears score, keeps high; reset mid-count loses everything.
        drive(2'b01, 1'b1);
        check("ng_clear", score_bcd, 16'h0000);
        run_to(42);
        reset_mid_cycle();

        // BCD carry.
        drive(2'b00, 1'b1);
        drive(2'b01, 1'b1);
        run_to(99);
        tick(2, 2'b01);
        check("carry100", score_bcd, 16'h0100);

        // High-score update rules and display of high in idle.
        run_to(123);
        drive(2'b11, 1'b1);
        check("high123", high_bcd, 16'h0123);
        drive(2'b00, 1'b1);
        drive(2'b00, 1'b1);
        check_display(16'h0123, 2'b00);
        drive(2'b01, 1'b1);
        check("restart", score_bcd, 16'h0000);
        run_to(50);
        drive(2'b11, 1'b1);
        check("high_keep", high_bcd, 16'h0123);
        drive(2'b00, 1'b1);
        drive(2'b01, 1'b1);
        run_to(200);
        drive(2'b11, 1'b1);
        check("high200", high_bcd, 16'h0200);

        // New game coincident with a tick: score and frame counter both cleared.
        drive(2'b00, 1'b1);
        drive(2'b01, 1'b0);
        check("prio_score", score_bcd, 16'h0000);
        drive(2'b01, 1'b1);
        tick(1, 2'b01);
        check("prio_frame", score_bcd, 16'h0000);
        tick(1, 2'b01);
        check("prio_next", score_bcd, 16'h0001);

        // Display mux while running.
        run_to(1234);
        drive(2'b01, 1'b1);
        check_display(16'h1234, 2'b01);

        // Saturation.
        run_to(9999);
        tick(8, 2'b01);
        check("sat", score_bcd, 16'h9999);
        drive(2'b11, 1'b1);
        check("high9999", high_bcd, 16'h9999);
        drive(2'b01, 1'b1);
        check("over_to_run", score_bcd, 16'h9999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
